// File: rtl/engine_dimm_sieve_configure_request_sequencer.sv
// -----------------------------------------------------------------------------
// engine_dimm_sieve_configure_request_sequencer
//
// Fetches the ALU configuration sequence for one sieve engine. A start pulse
// issues ENGINE_SEQ_WIDTH ascending-offset read requests into the engine's
// window of the configuration region. The module tracks the responses, which
// may return in any order. It then waits for the configure-memory stage to
// report the assembled packet.
//
// Ports
//   ap_clk, ap_rst_n       clock, asynchronous active-low reset
//   start_in               one-cycle pulse, begins a load (accepted in IDLE/ERROR)
//   base_address_in        byte base of config region, latched on accepted start
//   fifo_setup_signal_in   downstream config FIFO still in reset (hold in SETUP)
//   request_valid_out      read request valid
//   request_ready_in       read request accepted when valid & ready
//   request_address_out    base + offset*8
//   request_offset_out     word offset of the current request
//   response_valid_in      memory response observed
//   response_offset_in     offset carried by the response
//   config_valid_in        assembled packet emitted by the config stage
//   busy_out               load in progress
//   done_out               one-cycle pulse, configuration delivered
//   error_out              sticky timeout / protocol error, cleared by start
// -----------------------------------------------------------------------------
module engine_dimm_sieve_configure_request_sequencer #(
   parameter int ID_RELATIVE      = 0,
   parameter int ENGINE_SEQ_WIDTH = 16,
   parameter int ENGINE_SEQ_MIN   = ID_RELATIVE * ENGINE_SEQ_WIDTH,
   parameter int OFFSET_WIDTH     = 16,
   parameter int MAX_OUTSTANDING  = 8,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    start_in,
   input  logic [63:0]             base_address_in,
   input  logic                    fifo_setup_signal_in,
   output logic                    request_valid_out,
   input  logic                    request_ready_in,
   output logic [63:0]             request_address_out,
   output logic [OFFSET_WIDTH-1:0] request_offset_out,
   input  logic                    response_valid_in,
   input  logic [OFFSET_WIDTH-1:0] response_offset_in,
   input  logic                    config_valid_in,
   output logic                    busy_out,
   output logic                    done_out,
   output logic                    error_out
);

   localparam int CNT_W = $clog2(ENGINE_SEQ_WIDTH + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   // A limit above the sequence length can never be reached; clamping keeps
   // the comparison inside the counter width.
   localparam int MAX_OUT_CLAMP = (MAX_OUTSTANDING > ENGINE_SEQ_WIDTH) ?
                                  ENGINE_SEQ_WIDTH : MAX_OUTSTANDING;

   localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]        SEQ_LAST_C = CNT_W'(ENGINE_SEQ_WIDTH);
   localparam logic [CNT_W-1:0]        MAX_OUT_C  = CNT_W'(MAX_OUT_CLAMP);
   localparam logic [TMR_W-1:0]        TMR_ONE    = TMR_W'(1);
   localparam logic [TMR_W-1:0]        TIMEOUT_C  = TMR_W'(TIMEOUT_CYCLES);
   localparam logic [OFFSET_WIDTH-1:0] SEQ_MIN_C  = OFFSET_WIDTH'(ENGINE_SEQ_MIN);
   localparam logic [OFFSET_WIDTH-1:0] SEQ_SPAN_C = OFFSET_WIDTH'(ENGINE_SEQ_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ISSUE,
      ST_DRAIN,
      ST_WAIT_CFG,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t                      state_q, state_d;
   logic [63:0]                 base_q, base_d;
   logic [CNT_W-1:0]            issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]            outstanding_q, outstanding_d;
   logic [ENGINE_SEQ_WIDTH-1:0] rx_mask_q, rx_mask_d;
   logic [TMR_W-1:0]            timer_q, timer_d;

   logic                        request_valid_q, request_valid_d;
   logic [63:0]                 address_q, address_d;
   logic [OFFSET_WIDTH-1:0]     offset_q, offset_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        error_q, error_d;

   // ---------------------------------------------------------------------
   // Response decode: window test and one-hot position in the rx mask
   // ---------------------------------------------------------------------
   logic [OFFSET_WIDTH-1:0]     resp_idx;
   logic                        resp_in_window;
   logic [ENGINE_SEQ_WIDTH-1:0] resp_hit;

   assign resp_idx       = response_offset_in - SEQ_MIN_C;
   assign resp_in_window = response_valid_in &&
                           (response_offset_in >= SEQ_MIN_C) &&
                           (resp_idx < SEQ_SPAN_C);

   for (genvar gi = 0; gi < ENGINE_SEQ_WIDTH; gi++) begin : g_hit
      assign resp_hit[gi] = resp_in_window && (resp_idx == OFFSET_WIDTH'(gi));
   end

   logic                        req_fire;
   logic                        resp_accept;
   logic                        resp_error;
   logic                        counting;
   logic                        activity;
   logic [TMR_W-1:0]            timer_inc;
   logic                        timed_out;

   assign req_fire    = request_valid_q & request_ready_in;
   // Only the load states consume responses; elsewhere they are dropped.
   assign resp_accept = resp_in_window &&
                        ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
   // A second answer for the same word, or an answer with nothing in flight.
   assign resp_error  = resp_accept &&
                        ((|(resp_hit & rx_mask_q)) || (outstanding_q == '0));

   assign counting  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN) ||
                      (state_q == ST_WAIT_CFG);
   assign activity  = req_fire | resp_accept | config_valid_in;
   assign timer_inc = timer_q + TMR_ONE;
   assign timed_out = counting && !activity && (timer_inc == TIMEOUT_C);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      issue_cnt_d   = issue_cnt_q;
      outstanding_d = outstanding_q;
      rx_mask_d     = rx_mask_q;

      unique case (state_q)
         ST_IDLE, ST_ERROR: begin
            if (start_in) begin
               base_d        = base_address_in;
               issue_cnt_d   = '0;
               outstanding_d = '0;
               rx_mask_d     = '0;
               state_d       = fifo_setup_signal_in ? ST_SETUP : ST_ISSUE;
            end
         end

         ST_SETUP: begin
            if (!fifo_setup_signal_in) begin
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE, ST_DRAIN: begin
            if (req_fire) begin
               issue_cnt_d = issue_cnt_q + CNT_ONE;
            end
            unique case ({req_fire, resp_accept})
               2'b10:   outstanding_d = outstanding_q + CNT_ONE;
               2'b01:   outstanding_d = outstanding_q - CNT_ONE;
               default: outstanding_d = outstanding_q;
            endcase
            if (resp_accept) begin
               rx_mask_d = rx_mask_q | resp_hit;
            end

            if (resp_error || timed_out) begin
               state_d = ST_ERROR;
            end else if ((state_q == ST_ISSUE) && (issue_cnt_d == SEQ_LAST_C)) begin
               state_d = ST_DRAIN;
            end else if ((state_q == ST_DRAIN) && (&rx_mask_d)) begin
               state_d = ST_WAIT_CFG;
            end
         end

         ST_WAIT_CFG: begin
            if (config_valid_in) begin
               state_d = ST_DONE;
            end else if (timed_out) begin
               state_d = ST_ERROR;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Idle timer restarts on any state change or forward progress.
      if ((state_d != state_q) || activity || !counting) begin
         timer_d = '0;
      end else begin
         timer_d = timer_inc;
      end

      // Outputs are decoded from the next state so they appear registered.
      request_valid_d = (state_d == ST_ISSUE) && (outstanding_d != MAX_OUT_C);
      offset_d        = '0;
      address_d       = '0;
      if (state_d == ST_ISSUE) begin
         offset_d  = SEQ_MIN_C + OFFSET_WIDTH'(issue_cnt_d);
         address_d = base_d + 64'({offset_d, 3'b000});
      end
      busy_d  = (state_d == ST_SETUP) || (state_d == ST_ISSUE) ||
                (state_d == ST_DRAIN) || (state_d == ST_WAIT_CFG);
      done_d  = (state_d == ST_DONE);
      // ERROR is left only through a start, so the flag is sticky.
      error_d = (state_d == ST_ERROR);
   end

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q         <= ST_IDLE;
         base_q          <= '0;
         issue_cnt_q     <= '0;
         outstanding_q   <= '0;
         rx_mask_q       <= '0;
         timer_q         <= '0;
         request_valid_q <= 1'b0;
         address_q       <= '0;
         offset_q        <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         base_q          <= base_d;
         issue_cnt_q     <= issue_cnt_d;
         outstanding_q   <= outstanding_d;
         rx_mask_q       <= rx_mask_d;
         timer_q         <= timer_d;
         request_valid_q <= request_valid_d;
         address_q       <= address_d;
         offset_q        <= offset_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         error_q         <= error_d;
      end
   end

   assign request_valid_out   = request_valid_q;
   assign request_address_out = address_q;
   assign request_offset_out  = offset_q;
   assign busy_out            = busy_q;
   assign done_out            = done_q;
   assign error_out           = error_q;

endmodule

// File: tb/tb_engine_dimm_sieve_configure_request_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for engine_dimm_sieve_configure_request_sequencer (engine slot 1,
// window offsets 16..31, 8 outstanding, 64-cycle timeout).
// Stimulus pushes expected request/done/error events into exp_q; a monitor on
// the falling edge pops and compares whenever the DUT presents one.
// -----------------------------------------------------------------------------
module tb_engine_dimm_sieve_configure_request_sequencer;

   localparam int EV_REQ  = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        start_in;
   logic [63:0] base_address_in;
   logic        fifo_setup_signal_in;
   logic        request_valid_out;
   logic        request_ready_in;
   logic [63:0] request_address_out;
   logic [15:0] request_offset_out;
   logic        response_valid_in;
   logic [15:0] response_offset_in;
   logic        config_valid_in;
   logic        busy_out;
   logic        done_out;
   logic        error_out;

   always #5 ap_clk = ~ap_clk;

   engine_dimm_sieve_configure_request_sequencer #(
      .ID_RELATIVE      (1),
      .ENGINE_SEQ_WIDTH (16),
      .OFFSET_WIDTH     (16),
      .MAX_OUTSTANDING  (8),
      .TIMEOUT_CYCLES   (64)
   ) dut (
      .ap_clk               (ap_clk),
      .ap_rst_n             (ap_rst_n),
      .start_in             (start_in),
      .base_address_in      (base_address_in),
      .fifo_setup_signal_in (fifo_setup_signal_in),
      .request_valid_out    (request_valid_out),
      .request_ready_in     (request_ready_in),
      .request_address_out  (request_address_out),
      .request_offset_out   (request_offset_out),
      .response_valid_in    (response_valid_in),
      .response_offset_in   (response_offset_in),
      .config_valid_in      (config_valid_in),
      .busy_out             (busy_out),
      .done_out             (done_out),
      .error_out            (error_out)
   );

   typedef struct {
      int          kind;
      logic [15:0] off;
      logic [63:0] addr;
   } ev_t;

   ev_t         exp_q[$];
   logic [15:0] pend_q[$];
   int          due_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          hs_count = 0;
   logic        auto_resp = 1'b0;
   logic        err_prev = 1'b0;

   // ---------------- scoreboard helpers ----------------
   task automatic push_req(input int off, input logic [63:0] base);
      ev_t e;
      e.kind = EV_REQ;
      e.off  = 16'(off);
      e.addr = base + (64'(off) << 3);
      exp_q.push_back(e);
   endtask

   task automatic push_ev(input int kind);
      ev_t e;
      e.kind = kind;
      e.off  = '0;
      e.addr = '0;
      exp_q.push_back(e);
   endtask

   task automatic mon_event(input int kind, input logic [15:0] off, input logic [63:0] addr);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d off %0d addr 0x%0h, expected none", kind, off, addr);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind == EV_REQ && (e.off !== off || e.addr !== addr))) begin
            errors++;
            $display("FAIL event_mismatch: got kind %0d off %0d addr 0x%0h, expected kind %0d off %0d addr 0x%0h",
                     kind, off, addr, e.kind, e.off, e.addr);
         end else begin
            $display("event kind %0d off %0d addr 0x%0h ok", kind, off, addr);
         end
      end
   endtask

   always @(negedge ap_clk) begin
      if (ap_rst_n) begin
         if (request_valid_out && request_ready_in)
            mon_event(EV_REQ, request_offset_out, request_address_out);
         if (done_out)
            mon_event(EV_DONE, 16'd0, 64'd0);
         if (error_out && !err_prev)
            mon_event(EV_ERR, 16'd0, 64'd0);
      end
      err_prev = error_out;
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   // One clock; optionally answers each handshake in order two cycles later.
   task automatic tick();
      if (request_valid_out && request_ready_in) begin
         hs_count++;
         if (auto_resp) begin
            pend_q.push_back(request_offset_out);
            due_q.push_back(cyc + 2);
         end
      end
      @(posedge ap_clk);
      #1;
      cyc++;
      if (auto_resp) begin
         if (pend_q.size() > 0 && due_q[0] <= cyc) begin
            response_valid_in  = 1'b1;
            response_offset_in = pend_q.pop_front();
            void'(due_q.pop_front());
         end else begin
            response_valid_in = 1'b0;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic resp(input int off);
      response_valid_in  = 1'b1;
      response_offset_in = 16'(off);
      tick();
      response_valid_in  = 1'b0;
   endtask

   task automatic pulse_start(input logic [63:0] base);
      base_address_in = base;
      hs_count = 0;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
   endtask

   // Exits with the last response on the bus (not yet seen by the DUT).
   task automatic wait_responses();
      int n;
      n = 0;
      while (!(hs_count >= 16 && pend_q.size() == 0) && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL wait_responses: got %0d handshakes expected 16 within bound", hs_count);
      end
   endtask

   task automatic run_load(input logic [63:0] base);
      for (int k = 0; k < 16; k++) push_req(16 + k, base);
      push_ev(EV_DONE);
      request_ready_in = 1'b1;
      pend_q.delete();
      due_q.delete();
      auto_resp = 1'b1;
      pulse_start(base);
      check_bit("busy_after_start", busy_out, 1'b1);
      check_bit("error_cleared_by_start", error_out, 1'b0);
      wait_responses();
      tick();
      config_valid_in = 1'b1;
      tick();
      config_valid_in = 1'b0;
      check_bit("done_pulse", done_out, 1'b1);
      check_bit("busy_low_in_done", busy_out, 1'b0);
      tick();
      check_bit("done_one_cycle", done_out, 1'b0);
      check_bit("busy_after_done", busy_out, 1'b0);
      auto_resp = 1'b0;
      response_valid_in = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t0;
      ap_rst_n             = 1'b0;
      start_in             = 1'b0;
      base_address_in      = '0;
      fifo_setup_signal_in = 1'b0;
      request_ready_in     = 1'b0;
      response_valid_in    = 1'b0;
      response_offset_in   = '0;
      config_valid_in      = 1'b0;
      ticks(2);
      check_bit("rst_valid", request_valid_out, 1'b0);
      check_bit("rst_busy", busy_out, 1'b0);
      check_bit("rst_done", done_out, 1'b0);
      check_bit("rst_error", error_out, 1'b0);
      check_val("rst_offset", 64'(request_offset_out), 64'd0);
      check_val("rst_address", request_address_out, 64'd0);
      ap_rst_n = 1'b1;
      tick();

      // 1: in-order load, offsets 16..31 at 0x1080..0x10F8
      $display("test 1 in-order load");
      run_load(64'h1000);

      // 2: outstanding limit, then ISSUE timeout
      $display("test 2 outstanding limit");
      for (int k = 0; k < 8; k++) push_req(16 + k, 64'h2000);
      request_ready_in = 1'b1;
      pulse_start(64'h2000);
      ticks(15);
      check_bit("t2_valid_at_limit", request_valid_out, 1'b0);
      check_val("t2_handshakes", 64'(hs_count), 64'd8);
      push_req(24, 64'h2000);
      resp(16);
      ticks(5);
      check_val("t2_one_more_handshake", 64'(hs_count), 64'd9);
      check_bit("t2_valid_after_refill", request_valid_out, 1'b0);
      push_ev(EV_ERR);
      for (int i = 0; i < 100 && !error_out; i++) tick();
      check_bit("t2_timeout_error", error_out, 1'b1);
      check_bit("t2_busy_in_error", busy_out, 1'b0);

      // 3: reverse-order responses with foreign offset 40 interleaved
      $display("test 3 reverse order");
      for (int k = 0; k < 16; k++) push_req(16 + k, 64'h3000);
      push_ev(EV_DONE);
      request_ready_in = 1'b1;
      pulse_start(64'h3000);
      check_bit("t3_error_cleared", error_out, 1'b0);
      ticks(12);
      for (int k = 23; k >= 16; k--) begin resp(k); resp(40); end
      ticks(4);
      for (int k = 31; k >= 25; k--) begin resp(k); resp(40); end
      config_valid_in = 1'b1;   // must be ignored while still draining
      tick();
      config_valid_in = 1'b0;
      ticks(2);
      check_bit("t3_busy_in_drain", busy_out, 1'b1);
      check_bit("t3_no_done_in_drain", done_out, 1'b0);
      resp(24);
      config_valid_in = 1'b1;
      tick();
      config_valid_in = 1'b0;
      check_bit("t3_done", done_out, 1'b1);
      tick();
      check_bit("t3_no_error", error_out, 1'b0);
      check_bit("t3_idle", busy_out, 1'b0);

      // 4: duplicate response -> ERROR, then restart clears it
      $display("test 4 duplicate response");
      push_req(16, 64'h4000);
      push_req(17, 64'h4000);
      push_ev(EV_ERR);
      request_ready_in = 1'b0;
      pulse_start(64'h4000);
      request_ready_in = 1'b1;
      ticks(2);
      request_ready_in = 1'b0;
      tick();
      resp(16);
      resp(16);
      ticks(2);
      check_bit("t4_error", error_out, 1'b1);
      check_bit("t4_valid_low", request_valid_out, 1'b0);
      check_bit("t4_busy_low", busy_out, 1'b0);
      run_load(64'h5000);

      // 5: long SETUP without timeout, then WAIT_CFG timeout
      $display("test 5 setup hold and wait_cfg timeout");
      for (int k = 0; k < 16; k++) push_req(16 + k, 64'h6000);
      push_ev(EV_ERR);
      fifo_setup_signal_in = 1'b1;
      request_ready_in = 1'b1;
      pulse_start(64'h6000);
      ticks(200);
      check_bit("t5_setup_valid", request_valid_out, 1'b0);
      check_bit("t5_setup_busy", busy_out, 1'b1);
      check_bit("t5_setup_no_timeout", error_out, 1'b0);
      fifo_setup_signal_in = 1'b0;
      pend_q.delete();
      due_q.delete();
      auto_resp = 1'b1;
      wait_responses();
      t0 = cyc;
      for (int i = 0; i < 200 && !error_out; i++) tick();
      auto_resp = 1'b0;
      response_valid_in = 1'b0;
      // one edge to take the last response, then 64 idle cycles in WAIT_CFG
      check_val("t5_timeout_latency", 64'(cyc - t0), 64'd65);
      check_bit("t5_error", error_out, 1'b1);

      // 6: asynchronous reset during ISSUE
      $display("test 6 reset mid-load");
      for (int k = 0; k < 8; k++) push_req(16 + k, 64'h7000);
      request_ready_in = 1'b0;
      pulse_start(64'h7000);
      for (int i = 0; i < 8; i++) begin
         request_ready_in = (i % 2 == 1);
         tick();
      end
      #2;
      ap_rst_n = 1'b0;
      #1;
      check_bit("t6_async_valid", request_valid_out, 1'b0);
      check_bit("t6_async_busy", busy_out, 1'b0);
      check_val("t6_async_offset", 64'(request_offset_out), 64'd0);
      check_val("t6_async_address", request_address_out, 64'd0);
      request_ready_in = 1'b0;
      exp_q.delete();   // abandoned requests are never presented
      tick();
      ap_rst_n = 1'b1;
      tick();
      check_bit("t6_post_reset_valid", request_valid_out, 1'b0);
      run_load(64'h8000);

      ticks(3);
      check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
